demux_1to8_reg: RTL and testbench

DEMUX_1TO8_REG -- requirements
Module: demux_1to8_reg

---
 rtl/demux_pkg.sv | 19 +
 rtl/mod8_counter.sv | 24 ++
 rtl/demux_1to8_reg.sv | 136 +++++++++++++
 tb/tb_demux_1to8_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and FSM state type
// for the registered 1-to-8 demux bank.
package demux_pkg;

  localparam int NREG  = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic is_last(
    input logic [PTR_W-1:0] p
  );
    return p == PTR_W'(NREG - 1);
  endfunction

endpackage

// File: rtl/mod8_counter.sv
// mod8_counter: 3-bit wrap-around counter
// with enable and synchronous load-zero.
module mod8_counter
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [PTR_W-1:0] q
);

  // load-zero wins over count; 7 wraps to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/demux_1to8_reg.sv
// demux_1to8_reg: 8-entry write bank with clear sweep.
// DEMUX_AUTOINC_EN adds Mode port and auto-inc WrPtr.
module demux_1to8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       Sel,
  input  logic             Wr,
  input  logic             Clr,
`ifdef DEMUX_AUTOINC_EN
  input  logic             Mode,
`endif
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [WIDTH-1:0] Out5,
  output logic [WIDTH-1:0] Out6,
  output logic [WIDTH-1:0] Out7,
  output logic [WIDTH-1:0] Out8,
  output logic [NREG-1:0]  Valid,
  output logic             Busy,
  output logic             Full
);

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic [PTR_W-1:0] sptr;
  logic [PTR_W-1:0] tgt;
  logic             wr_acc;
  logic             sweep_end;
  logic [NREG-1:0]  valid_nxt;
  logic [WIDTH-1:0] bank [NREG];

  assign wr_acc    = (state == IDLE) && Wr && !Clr;
  assign sweep_end = (state == CLEAR) && is_last(sptr);

  mod8_counter u_sweep (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == CLEAR),
    .clr   (state == IDLE),
    .q     (sptr)
  );

`ifdef DEMUX_AUTOINC_EN
  logic [PTR_W-1:0] WrPtr;

  mod8_counter u_wrptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_acc && Mode),
    .clr   (sweep_end),
    .q     (WrPtr)
  );

  assign tgt = Mode ? WrPtr : Sel;
`else
  assign tgt = Sel;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: Clr starts a sweep, last step ends it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Clr) state_nxt = CLEAR;
      CLEAR:   if (is_last(sptr)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: Busy registered from next state
  always_comb begin
    busy_nxt = (state_nxt == CLEAR);
  end

  // next valid vector: sweep clears, write sets
  always_comb begin
    valid_nxt = Valid;
    unique case (1'b1)
      state == CLEAR: valid_nxt[sptr] = 1'b0;
      wr_acc:         valid_nxt[tgt]  = 1'b1;
      default: ;
    endcase
  end

  // status flops: Busy, Valid, Full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Busy  <= 1'b0;
      Valid <= '0;
      Full  <= 1'b0;
    end else begin
      Busy  <= busy_nxt;
      Valid <= valid_nxt;
      Full  <= &valid_nxt;
    end
  end

  // data bank: sweep zeroes one entry per cycle, else write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        bank[i] <= '0;
      end
    end else if (state == CLEAR) begin
      bank[sptr] <= '0;
    end else if (wr_acc) begin
      bank[tgt] <= In;
    end
  end

  assign Out1 = bank[0];
  assign Out2 = bank[1];
  assign Out3 = bank[2];
  assign Out4 = bank[3];
  assign Out5 = bank[4];
  assign Out6 = bank[5];
  assign Out7 = bank[6];
  assign Out8 = bank[7];

endmodule

// File: tb/tb_demux_1to8_reg.sv
// tb_demux_1to8_reg: directed self-checking bench
// for demux_1to8_reg (WIDTH=4).
module tb_demux_1to8_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] In = '0;
  logic [2:0] Sel = '0;
  logic       Wr = 1'b0;
  logic       Clr = 1'b0;
`ifdef DEMUX_AUTOINC_EN
  logic       Mode = 1'b0;
`endif
  logic [3:0] o1, o2, o3, o4, o5, o6, o7, o8;
  logic [7:0] Valid;
  logic       Busy;
  logic       Full;
  logic [3:0] outs [8];

  int checks = 0;
  int failures = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  assign outs[0] = o1;
  assign outs[1] = o2;
  assign outs[2] = o3;
  assign outs[3] = o4;
  assign outs[4] = o5;
  assign outs[5] = o6;
  assign outs[6] = o7;
  assign outs[7] = o8;

  demux_1to8_reg #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .In    (In),
    .Sel   (Sel),
    .Wr    (Wr),
    .Clr   (Clr),
`ifdef DEMUX_AUTOINC_EN
    .Mode  (Mode),
`endif
    .Out1  (o1),
    .Out2  (o2),
    .Out3  (o3),
    .Out4  (o4),
    .Out5  (o5),
    .Out6  (o6),
    .Out7  (o7),
    .Out8  (o8),
    .Valid (Valid),
    .Busy  (Busy),
    .Full  (Full)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    Wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Sel = 3'(i);
      In  = 4'(i + 1);
      step();
    end
    Wr = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_out4", {28'h0, o4}, 0);
    check("rst_valid", {24'h0, Valid}, 0);
    check("rst_busy", {31'h0, Busy}, 0);
    check("rst_full", {31'h0, Full}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // direct writes
    Wr = 1'b1; Sel = 3'd3; In = 4'hA;
    step();
    check("lat1_out4", {28'h0, o4}, 32'hA);
    Sel = 3'd7; In = 4'h5;
    step();
    Wr = 1'b0;
    check("dir_out8", {28'h0, o8}, 32'h5);
    check("dir_valid", {24'h0, Valid}, 32'h88);
    for (int i = 0; i < 8; i++) begin
      if (i != 3 && i != 7)
        check($sformatf("dir_zero%0d", i),
              {28'h0, outs[i]}, 0);
    end

    // fill and sweep
    fill();
    check("fill_full", {31'h0, Full}, 1);
    check("fill_out4", {28'h0, o4}, 4);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    busy_cnt = 0;
    if (Busy) busy_cnt++;
    check("sw_busy0", {31'h0, Busy}, 1);
    check("sw_full0", {31'h0, Full}, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      if (Busy) busy_cnt++;
      check($sformatf("sw_clr%0d", k),
            {28'h0, outs[k]}, 0);
      if (k < 7)
        check($sformatf("sw_hold%0d", k),
              {28'h0, outs[k+1]}, 32'(k + 2));
      if (k == 0)
        check("sw_full_fall", {31'h0, Full}, 0);
    end
    check("sw_busy_cnt", busy_cnt, 8);
    check("sw_valid_end", {24'h0, Valid}, 0);
    check("sw_busy_end", {31'h0, Busy}, 0);

    // collision: Clr beats Wr, sweep ignores Wr/Clr
    Wr = 1'b1; Sel = 3'd2; In = 4'hF; Clr = 1'b1;
    step();
    check("col_out3", {28'h0, o3}, 0);
    check("col_busy", {31'h0, Busy}, 1);
    In = 4'h9;
    for (int k = 0; k < 8; k++) begin
      Sel = 3'(k);
      step();
    end
    Wr = 1'b0; Clr = 1'b0;
    check("col_busy_end", {31'h0, Busy}, 0);
    check("col_valid", {24'h0, Valid}, 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("col_zero%0d", i),
            {28'h0, outs[i]}, 0);
    step();
    check("col_noqueue", {31'h0, Busy}, 0);

    // reset mid-sweep
    fill();
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    step(); step(); step();
    check("mid_out5", {28'h0, o5}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_out5_rst", {28'h0, o5}, 0);
    check("mid_out8_rst", {28'h0, o8}, 0);
    check("mid_valid", {24'h0, Valid}, 0);
    check("mid_busy", {31'h0, Busy}, 0);
    check("mid_full", {31'h0, Full}, 0);
    #2;
    rst_n = 1'b1;
    Wr = 1'b1; Sel = 3'd1; In = 4'h6;
    step();
    Wr = 1'b0;
    check("post_out2", {28'h0, o2}, 6);
    check("post_valid", {24'h0, Valid}, 32'h02);
    check("post_busy", {31'h0, Busy}, 0);

    // rewrite of a valid register
    Wr = 1'b1; Sel = 3'd1; In = 4'h3;
    step();
    Wr = 1'b0;
    check("rew_out2", {28'h0, o2}, 3);
    check("rew_valid", {24'h0, Valid}, 32'h02);

`ifdef DEMUX_AUTOINC_EN
    // auto-increment with wrap
    Mode = 1'b1; Wr = 1'b1; Sel = 3'd5;
    for (int i = 0; i < 10; i++) begin
      In = 4'(i);
      step();
    end
    Wr = 1'b0;
    check("ai_out1", {28'h0, o1}, 8);
    check("ai_out2", {28'h0, o2}, 9);
    for (int i = 2; i < 8; i++)
      check($sformatf("ai_out%0d", i + 1),
            {28'h0, outs[i]}, 32'(i));
    check("ai_valid", {24'h0, Valid}, 32'hFF);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    for (int k = 0; k < 8; k++) step();
    Wr = 1'b1; In = 4'hC;
    step();
    Wr = 1'b0; Mode = 1'b0;
    check("ai_ptr_rst", {28'h0, o1}, 32'hC);
    check("ai_ptr_v", {24'h0, Valid}, 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
